// File: rtl/ecdsa_verify_ctrl_pkg.sv
// Shared types for the ECDSA verify controller: request metadata, queued
// descriptors and the two FSM state encodings.
package meta_package;

    typedef struct packed {
        logic [7:0] tag;
        logic       bypass;
        logic [3:0] key_idx;
    } ecdsa_req_meta_t;

    typedef struct packed {
        logic [7:0] tag;
        logic       bypass;
        logic       malformed;
    } ecdsa_desc_t;

    typedef enum logic {OUT_PKT, IN_PKT} frame_state_e;

    typedef enum logic [1:0] {IDLE, BUSY, RESP} eng_state_e;

    localparam int BEAT_CNT_W = 8;

    function automatic logic [BEAT_CNT_W-1:0] sat_inc8(input logic [BEAT_CNT_W-1:0] c);
        return (c == 8'hFF) ? c : c + 8'd1;
    endfunction

endpackage

// File: rtl/ecdsa_verify_ctrl_fifo.sv
// Descriptor queue for the verify controller. A second write port lets an
// aborted packet and a single-beat packet land in the same cycle.
module ecdsa_desc_fifo
    import meta_package::*;
#(
    parameter int DESC_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  ecdsa_desc_t push_data,
    input  logic        push2,
    input  ecdsa_desc_t push2_data,
    input  logic        pop,
    output ecdsa_desc_t pop_data,
    output logic        full,
    output logic        empty,
    output logic        one_free
);

    localparam int AW = $clog2(DESC_DEPTH);

    ecdsa_desc_t     mem_q [DESC_DEPTH];
    logic [AW-1:0]   wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]     cnt_q, cnt_d;

    assign full     = (cnt_q == (AW+1)'(DESC_DEPTH));
    assign empty    = (cnt_q == '0);
    assign one_free = (cnt_q == (AW+1)'(DESC_DEPTH - 1));
    assign pop_data = mem_q[rd_q];

    always_comb begin
        wr_d  = wr_q + AW'(push) + AW'(push2);
        rd_d  = rd_q + AW'(pop);
        cnt_d = cnt_q + (AW+1)'(push) + (AW+1)'(push2) - (AW+1)'(pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    // push2 always follows push, so it occupies the slot after wr_q.
    always_ff @(posedge clk) begin
        if (push)  mem_q[wr_q]         <= push_data;
        if (push2) mem_q[wr_q + AW'(1)] <= push2_data;
    end

endmodule

// File: rtl/ecdsa_verify.sv
// Top of the ECDSA verify controller: packet framing, descriptor queue and a
// fixed-latency engine model. Define ECDSA_VERIFY_STATS_EN for result counters.
module ecdsa_verify_ctrl
    import meta_package::*;
#(
    parameter int DATA_W     = 512,
    parameter int MIN_BEATS  = 2,
    parameter int MAX_BEATS  = 16,
    parameter int VERIFY_LAT = 32,
    parameter int DESC_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_hdr_data,
    input  ecdsa_req_meta_t   in_meta_data,
    input  logic              in_sop,
    input  logic              in_eop,
    output logic              signature_valid,
    output logic              signature_verified,
    output logic [7:0]        signature_tag,
    output logic              err_orphan
`ifdef ECDSA_VERIFY_STATS_EN
    ,
    output logic [31:0]       stat_ok,
    output logic [31:0]       stat_fail,
    output logic [31:0]       stat_orphan
`endif
);

    localparam int BW = (VERIFY_LAT > 1) ? $clog2(VERIFY_LAT) : 1;

    logic            full, empty, one_free, push, push2, pop, accept;
    ecdsa_desc_t     push_data, push2_data, pop_data, cur_q, cur_d;
    frame_state_e    frm_q, frm_d;
    eng_state_e      eng_q, eng_d;
    logic [7:0]      tag_q, tag_d, cnt_q, cnt_d, cnt_inc;
    logic            byp_q, byp_d, orphan_q, orphan_d;
    logic [BW-1:0]   busy_q, busy_d;
    logic            unused_inputs;

    assign unused_inputs = ^{in_hdr_data, in_meta_data.key_idx};

    function automatic logic malformed(input logic [7:0] c);
        return (int'(c) < MIN_BEATS) || (int'(c) > MAX_BEATS);
    endfunction

    ecdsa_desc_fifo #(.DESC_DEPTH(DESC_DEPTH)) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_data  (push_data),
        .push2      (push2),
        .push2_data (push2_data),
        .pop        (pop),
        .pop_data   (pop_data),
        .full       (full),
        .empty      (empty),
        .one_free   (one_free)
    );

    // An abort plus a single-beat packet needs two slots, so refuse that beat
    // when only one is left.
    assign in_ready = !rst && !full && !(frm_q == IN_PKT && in_sop && in_eop && one_free);
    assign accept   = in_valid && in_ready;
    assign cnt_inc  = sat_inc8(cnt_q);

    always_comb begin
        frm_d      = frm_q;
        tag_d      = tag_q;
        byp_d      = byp_q;
        cnt_d      = cnt_q;
        orphan_d   = 1'b0;
        push       = 1'b0;
        push2      = 1'b0;
        push_data  = '0;
        push2_data = '0;
        if (accept) begin
            if (in_sop) begin
                tag_d = in_meta_data.tag;
                byp_d = in_meta_data.bypass;
                cnt_d = 8'd1;
                frm_d = in_eop ? OUT_PKT : IN_PKT;
                if (frm_q == IN_PKT) begin
                    push      = 1'b1;
                    push_data = '{tag: tag_q, bypass: byp_q, malformed: 1'b1};
                    if (in_eop) begin
                        push2      = 1'b1;
                        push2_data = '{tag: in_meta_data.tag, bypass: in_meta_data.bypass,
                                       malformed: malformed(8'd1)};
                    end
                end else if (in_eop) begin
                    push      = 1'b1;
                    push_data = '{tag: in_meta_data.tag, bypass: in_meta_data.bypass,
                                  malformed: malformed(8'd1)};
                end
            end else if (frm_q == IN_PKT) begin
                cnt_d = cnt_inc;
                if (in_eop) begin
                    frm_d     = OUT_PKT;
                    push      = 1'b1;
                    push_data = '{tag: tag_q, bypass: byp_q, malformed: malformed(cnt_inc)};
                end
            end else begin
                orphan_d = 1'b1;
            end
        end
    end

    always_comb begin
        eng_d  = eng_q;
        busy_d = busy_q;
        cur_d  = cur_q;
        pop    = 1'b0;
        unique case (eng_q)
            IDLE: begin
                if (!empty) begin
                    pop    = 1'b1;
                    cur_d  = pop_data;
                    busy_d = BW'(VERIFY_LAT - 1);
                    eng_d  = pop_data.bypass ? RESP : BUSY;
                end
            end
            BUSY: begin
                if (busy_q == '0) eng_d = RESP;
                else              busy_d = busy_q - BW'(1);
            end
            RESP:    eng_d = IDLE;
            default: eng_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frm_q    <= OUT_PKT;
            tag_q    <= '0;
            byp_q    <= 1'b0;
            cnt_q    <= '0;
            orphan_q <= 1'b0;
            eng_q    <= IDLE;
            busy_q   <= '0;
            cur_q    <= '0;
        end else begin
            frm_q    <= frm_d;
            tag_q    <= tag_d;
            byp_q    <= byp_d;
            cnt_q    <= cnt_d;
            orphan_q <= orphan_d;
            eng_q    <= eng_d;
            busy_q   <= busy_d;
            cur_q    <= cur_d;
        end
    end

    assign signature_valid    = (eng_q == RESP);
    assign signature_verified = signature_valid && (cur_q.bypass || !cur_q.malformed);
    assign signature_tag      = signature_valid ? cur_q.tag : 8'h00;
    assign err_orphan         = orphan_q;

`ifdef ECDSA_VERIFY_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_ok     <= '0;
            stat_fail   <= '0;
            stat_orphan <= '0;
        end else begin
            if (signature_valid && signature_verified)  stat_ok     <= stat_ok + 32'd1;
            if (signature_valid && !signature_verified) stat_fail   <= stat_fail + 32'd1;
            if (err_orphan)                             stat_orphan <= stat_orphan + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ecdsa_verify_ctrl.sv
// Bench for ecdsa_verify_ctrl: directed packets, a transaction-level result
// model checked every cycle, and literal latency/tag expectations.
module tb_ecdsa_verify_ctrl;
    import meta_package::*;

    localparam int VL   = 32;
    localparam int MINB = 2;
    localparam int MAXB = 16;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [511:0]    in_hdr_data = '0;
    ecdsa_req_meta_t in_meta_data = '0;
    logic            in_sop = 1'b0;
    logic            in_eop = 1'b0;
    logic            signature_valid, signature_verified, err_orphan;
    logic [7:0]      signature_tag;
`ifdef ECDSA_VERIFY_STATS_EN
    logic [31:0]     stat_ok, stat_fail, stat_orphan;
`endif

    ecdsa_verify_ctrl dut (
        .clk                (clk),
        .rst                (rst),
        .in_valid           (in_valid),
        .in_ready           (in_ready),
        .in_hdr_data        (in_hdr_data),
        .in_meta_data       (in_meta_data),
        .in_sop             (in_sop),
        .in_eop             (in_eop),
        .signature_valid    (signature_valid),
        .signature_verified (signature_verified),
        .signature_tag      (signature_tag),
        .err_orphan         (err_orphan)
`ifdef ECDSA_VERIFY_STATS_EN
        ,
        .stat_ok            (stat_ok),
        .stat_fail          (stat_fail),
        .stat_orphan        (stat_orphan)
`endif
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int last_acc = 0;
    int n_strobes = 0;
    logic saw_stall = 1'b0;

    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Transaction model: results in acceptance order, each with its due cycle.
    typedef struct {
        int         t;
        logic [7:0] tag;
        logic       ver;
    } exp_t;

    exp_t       exp_q[$];
    int         eng_free = 0;
    logic       m_in_pkt = 1'b0;
    logic [7:0] m_tag = '0;
    logic       m_byp = 1'b0;
    int         m_cnt = 0;
    logic       orphan_pend = 1'b0;

    function automatic void model_push(input logic [7:0] tag, input logic byp, input logic good);
        exp_t e;
        int   start;
        start    = (cyc + 1 > eng_free) ? cyc + 1 : eng_free;
        e.t      = start + (byp ? 1 : VL + 1);
        e.tag    = tag;
        e.ver    = byp | good;
        eng_free = e.t + 1;
        exp_q.push_back(e);
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            eng_free    = 0;
            m_in_pkt    = 1'b0;
            m_cnt       = 0;
            orphan_pend = 1'b0;
            chk("rst_valid", 32'(signature_valid), 32'd0);
            chk("rst_verified", 32'(signature_verified), 32'd0);
            chk("rst_tag", 32'(signature_tag), 32'd0);
            chk("rst_orphan", 32'(err_orphan), 32'd0);
            chk("rst_ready", 32'(in_ready), 32'd0);
        end else begin
            if (exp_q.size() > 0 && exp_q[0].t == cyc) begin
                chk("res_valid", 32'(signature_valid), 32'd1);
                chk("res_tag", 32'(signature_tag), 32'(exp_q[0].tag));
                chk("res_verified", 32'(signature_verified), 32'(exp_q[0].ver));
                void'(exp_q.pop_front());
            end else begin
                chk("no_valid", 32'(signature_valid), 32'd0);
            end
            chk("orphan", 32'(err_orphan), 32'(orphan_pend));
            orphan_pend = 1'b0;
            if (signature_valid) n_strobes++;
            if (in_valid && !in_ready) saw_stall = 1'b1;
            if (in_valid && in_ready) begin
                if (in_sop) begin
                    if (m_in_pkt) model_push(m_tag, m_byp, 1'b0);
                    m_tag = in_meta_data.tag;
                    m_byp = in_meta_data.bypass;
                    m_cnt = 1;
                    if (in_eop) begin
                        model_push(m_tag, m_byp, (1 >= MINB) && (1 <= MAXB));
                        m_in_pkt = 1'b0;
                    end else begin
                        m_in_pkt = 1'b1;
                    end
                end else if (m_in_pkt) begin
                    if (m_cnt < 255) m_cnt++;
                    if (in_eop) begin
                        model_push(m_tag, m_byp, (m_cnt >= MINB) && (m_cnt <= MAXB));
                        m_in_pkt = 1'b0;
                    end
                end else begin
                    orphan_pend = 1'b1;
                end
            end
        end
    end

    // Drives one beat from posedge+1 until accepted; returns at posedge+1.
    task automatic beat(input logic s, input logic e, input logic [7:0] tag, input logic b);
        logic acc;
        int   n;
        in_valid     = 1'b1;
        in_sop       = s;
        in_eop       = e;
        in_meta_data = '{tag: tag, bypass: b, key_idx: 4'h5};
        in_hdr_data  = {16{$urandom()}};
        n   = 0;
        acc = 1'b0;
        while (!acc && n < 400) begin
            @(negedge clk);
            acc = in_ready;
            if (acc) last_acc = cyc;
            @(posedge clk);
            #1;
            n++;
        end
        if (!acc) chk("beat_accept_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
        in_sop   = 1'b0;
        in_eop   = 1'b0;
    endtask

    task automatic wait_result(input int budget, output int at, output logic ver,
                               output logic [7:0] tg);
        logic ok;
        ok  = 1'b0;
        at  = -1;
        ver = 1'b0;
        tg  = '0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            if (signature_valid) begin
                at  = cyc;
                ver = signature_verified;
                tg  = signature_tag;
                ok  = 1'b1;
            end
        end
        if (!ok) chk("result_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "watchdog");
    end

    int         at, at2, eopc, s0;
    logic       ver, ver2;
    logic [7:0] tg, tg2;
    int         eop_at[6];
    int         res_at[6];

    initial begin
        #1 rst = 1'b1;
        @(negedge clk);
        chk("reset_ready_low", 32'(in_ready), 32'd0);
        chk("reset_valid_low", 32'(signature_valid), 32'd0);
        idle(2);
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_release", 32'(in_ready), 32'd1);
        idle(1);

        // 4-beat packet, tag 0x11
        beat(1, 0, 8'h11, 0);
        beat(0, 0, 8'hEE, 1);
        beat(0, 0, 8'hEE, 1);
        beat(0, 1, 8'hEE, 1);
        eopc = last_acc;
        wait_result(100, at, ver, tg);
        chk("p4_latency", 32'(at - eopc), 32'd34);
        chk("p4_verified", 32'(ver), 32'd1);
        chk("p4_tag", 32'(tg), 32'h11);
        idle(3);

        // single-beat packet, bypass 0 then bypass 1
        beat(1, 1, 8'h33, 0);
        eopc = last_acc;
        wait_result(100, at, ver, tg);
        chk("p1_latency", 32'(at - eopc), 32'd34);
        chk("p1_verified", 32'(ver), 32'd0);
        chk("p1_tag", 32'(tg), 32'h33);
        idle(2);
        beat(1, 1, 8'h44, 1);
        eopc = last_acc;
        wait_result(100, at, ver, tg);
        chk("byp_latency", 32'(at - eopc), 32'd2);
        chk("byp_verified", 32'(ver), 32'd1);
        chk("byp_tag", 32'(tg), 32'h44);
        idle(3);

        // 3 beats then a new sop aborts the open packet
        beat(1, 0, 8'h21, 0);
        beat(0, 0, 8'hEE, 0);
        beat(0, 0, 8'hEE, 0);
        beat(1, 0, 8'h22, 0);
        eopc = last_acc;
        beat(0, 1, 8'hEE, 0);
        wait_result(100, at, ver, tg);
        wait_result(100, at2, ver2, tg2);
        chk("abort_latency", 32'(at - eopc), 32'd34);
        chk("abort_verified", 32'(ver), 32'd0);
        chk("abort_tag", 32'(tg), 32'h21);
        chk("after_abort_gap", 32'(at2 - at), 32'd34);
        chk("after_abort_verified", 32'(ver2), 32'd1);
        chk("after_abort_tag", 32'(tg2), 32'h22);
        idle(3);

        // 17-beat packet is too long
        beat(1, 0, 8'h55, 0);
        for (int i = 0; i < 15; i++) beat(0, 0, 8'hEE, 0);
        beat(0, 1, 8'hEE, 0);
        wait_result(100, at, ver, tg);
        chk("long_verified", 32'(ver), 32'd0);
        chk("long_tag", 32'(tg), 32'h55);
        idle(3);

        // orphan beat outside a packet
        s0 = n_strobes;
        beat(0, 1, 8'h99, 0);
        eopc = last_acc;
        @(negedge clk);
        chk("orphan_pulse", 32'(err_orphan), 32'd1);
        chk("orphan_cycle", 32'(cyc - eopc), 32'd1);
        idle(60);
        chk("orphan_no_strobe", 32'(n_strobes - s0), 32'd0);

        // six back-to-back 2-beat packets against a 4-deep queue
        saw_stall = 1'b0;
        fork
            begin
                for (int p = 0; p < 6; p++) begin
                    beat(1, 0, 8'(8'h60 + p), 0);
                    beat(0, 1, 8'hEE, 1);
                    eop_at[p] = last_acc;
                end
            end
            begin
                int         a;
                logic       v;
                logic [7:0] g;
                for (int p = 0; p < 6; p++) begin
                    wait_result(400, a, v, g);
                    res_at[p] = a;
                    chk("burst_tag", 32'(g), 32'(8'h60 + p));
                    chk("burst_verified", 32'(v), 32'd1);
                end
            end
        join
        chk("burst_stalled", 32'(saw_stall), 32'd1);
        chk("burst_first_latency", 32'(res_at[0] - eop_at[0]), 32'd34);
        for (int p = 1; p < 6; p++) chk("burst_spacing", 32'(res_at[p] - res_at[p-1]), 32'd34);
        idle(3);

        // reset in the middle of BUSY
        beat(1, 0, 8'h77, 0);
        beat(0, 1, 8'hEE, 0);
        idle(10);
        rst = 1'b1;
        @(negedge clk);
        chk("midbusy_rst_valid", 32'(signature_valid), 32'd0);
        chk("midbusy_rst_ready", 32'(in_ready), 32'd0);
        idle(2);
        rst = 1'b0;
        s0 = n_strobes;
        @(negedge clk);
        chk("midbusy_ready_release", 32'(in_ready), 32'd1);
        idle(60);
        chk("midbusy_no_strobe", 32'(n_strobes - s0), 32'd0);
        beat(1, 0, 8'h78, 0);
        beat(0, 1, 8'hEE, 0);
        eopc = last_acc;
        wait_result(100, at, ver, tg);
        chk("post_rst_latency", 32'(at - eopc), 32'd34);
        chk("post_rst_verified", 32'(ver), 32'd1);
        chk("post_rst_tag", 32'(tg), 32'h78);
        idle(5);
        chk("model_drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ecdsa_verify_ctrl.md
ECDSA_VERIFY_CTRL -- requirements
Module: ecdsa_verify_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 512, header-beat width in bits.
REQ-002 SHALL have parameter MIN_BEATS, default 2, fewest beats in a well-formed packet.
REQ-003 SHALL have parameter MAX_BEATS, default 16, most beats in a well-formed packet; range MIN_BEATS..255.
REQ-004 SHALL have parameter VERIFY_LAT, default 32, engine busy cycles per non-bypass request; minimum 1.
REQ-005 SHALL have parameter DESC_DEPTH, default 4, descriptor queue depth; power of two, minimum 2.
REQ-006 SHALL have port clk  in  1  sole clock, rising edge.
REQ-007 SHALL have port rst  in  1  reset, asynchronous and active-high.
REQ-008 SHALL have port in_valid  in  1  beat valid.
REQ-009 SHALL have port in_ready  out  1  beat accepted when in_valid&in_ready.
REQ-010 SHALL have port in_hdr_data  in  DATA_W  beat payload; ignored by this block except for framing.
REQ-011 SHALL have port in_meta_data  in  ecdsa_req_meta_t  request metadata; sampled on the sop beat only.
REQ-012 SHALL have port in_sop  in  1  first beat of a packet.
REQ-013 SHALL have port in_eop  in  1  last beat of a packet.
REQ-014 SHALL have port signature_valid  out  1  one-cycle result strobe.
REQ-015 SHALL have port signature_verified  out  1  result; meaningful only while signature_valid.
REQ-016 SHALL have port signature_tag  out  8  tag copied from the request meta; meaningful only while signature_valid.
REQ-017 SHALL have port err_orphan  out  1  one-cycle pulse when an accepted beat arrives outside a packet without sop.

Function
REQ-018 SHALL drive in_ready = !desc_full, combinationally from queue state.
REQ-019 SHALL track framing with FSM states OUT_PKT and IN_PKT.
REQ-020 SHALL, on an accepted sop: latch meta, set beat count to 1, and enter IN_PKT, or stay in OUT_PKT if eop is also set.
REQ-021 SHALL, on an accepted non-sop beat in IN_PKT, increment the beat count, saturating at 255.
REQ-022 SHALL, on an accepted eop, write a descriptor {tag, bypass, malformed} the following edge; malformed = count<MIN_BEATS or count>MAX_BEATS, with the count including the eop beat.
REQ-023 SHALL, on a sop accepted while in IN_PKT, write the open packet as a malformed descriptor and start the new packet in the same cycle; when the queue has only one free slot, in_ready SHALL be low for that beat.
REQ-024 SHALL, on a non-sop beat accepted in OUT_PKT, drop it, pulse err_orphan the next cycle, and write no descriptor.
REQ-025 SHALL run engine FSM states IDLE, BUSY and RESP.
REQ-026 SHALL, in IDLE with the queue non-empty, pop one descriptor; bypass=1 -> RESP next, else BUSY.
REQ-027 SHALL keep BUSY for exactly VERIFY_LAT cycles using a down-counter, then go to RESP.
REQ-028 SHALL, in RESP, assert signature_valid for one cycle with signature_verified = bypass | !malformed, then return to IDLE.
REQ-029 SHALL meet latency, empty queue and idle engine: eop accepted in cycle 0 -> signature_valid in cycle VERIFY_LAT+2 (non-bypass) or cycle 2 (bypass).
REQ-030 SHALL produce results in acceptance order, one per eop/abort, never dropped or duplicated.
REQ-031 SHALL keep the queue correct under simultaneous push and pop when full: pop frees a slot, and in_ready still reflects the pre-pop full state.

Reset
REQ-032 SHALL, on rst, asynchronously force OUT_PKT, IDLE, empty queue, zero counters, and signature_valid, signature_verified, signature_tag and err_orphan to 0.
REQ-033 SHALL hold in_ready low while rst is high and assert it the first cycle after release.
REQ-034 SHALL discard, on reset mid-packet or mid-BUSY, any partial packet and pending result, with no strobe after release.

Configuration
REQ-035 SHALL, with ECDSA_VERIFY_STATS_EN defined, add outputs stat_ok, stat_fail and stat_orphan (32 bits each, wrapping, reset 0), incremented on verified results, failed results and err_orphan respectively.
REQ-036 SHALL, without ECDSA_VERIFY_STATS_EN, omit those ports and counters entirely; all other behaviour SHALL be identical.

Structure
REQ-037 SHALL define ecdsa_req_meta_t {tag[7:0], bypass, key_idx[3:0]} and ecdsa_desc_t in meta_package.
REQ-038 SHALL implement the descriptor queue as sub-module ecdsa_desc_fifo, parameterised by DESC_DEPTH and exposing full, empty, push and pop.

Verification
REQ-039 SHALL cover: 4-beat packet, tag 0x11, bypass 0, VERIFY_LAT 32 -> signature_valid at cycle 34 after eop, verified 1, tag 0x11.
REQ-040 SHALL cover: 1-beat packet (sop&eop), bypass 0 -> verified 0 after 34 cycles; same packet with bypass 1 -> verified 1 at cycle 2.
REQ-041 SHALL cover: 3 beats then a new sop, tag 0x22 -> malformed result for the first packet, verified 0; second packet completes normally.
REQ-042 SHALL cover: beat with no sop in OUT_PKT -> err_orphan pulse, no signature_valid ever.
REQ-043 SHALL cover: 6 back-to-back 2-beat packets with DESC_DEPTH 4 -> in_ready drops while full, 6 results in order at 34-cycle spacing.
REQ-044 SHALL cover: rst asserted mid-BUSY -> outputs 0 immediately, no strobe after release, next packet verified normally.
